// File: rtl/nes_dma_pkg.sv
// nes_dma_pkg: shared types and defaults for the sprite OAM DMA path.
// Contents: dma_state_t FSM encoding, default trigger address, default transfer length.
package nes_dma_pkg;
    typedef enum logic [2:0] {IDLE, DUMMY, ALIGN, READ, WRITE} dma_state_t;
    localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'h4014;
    localparam int XFER_LEN_DEFAULT = 256;
endpackage

// File: rtl/oam_dma_ctrl_if.sv
// oam_dma_ctrl_if: CPU bus, CPU-space read port and PPU OAM write port of the OAM DMA.
// master: the DMA controller (drives stall, memory read and OAM write signals).
// slave : the surrounding system (CPU bus, memory mux, PPU).
interface oam_dma_ctrl_if;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic [7:0]  oam_base;
    logic        cpu_stall;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_in;
    logic        oam_dma;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data_out;
    logic        done;
    modport master (
        input  cpu_wr, cpu_addr, cpu_data_in, oam_base, mem_data_in,
        output cpu_stall, mem_rd, mem_addr, oam_dma, oam_we, oam_addr, oam_data_out, done
    );
    modport slave (
        output cpu_wr, cpu_addr, cpu_data_in, oam_base, mem_data_in,
        input  cpu_stall, mem_rd, mem_addr, oam_dma, oam_we, oam_addr, oam_data_out, done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: CPU write to DMA_REG_ADDR stalls the CPU and copies one page into PPU OAM.
// Ports: clk, reset (async, active-high), bus (oam_dma_ctrl_if.master: CPU write
// detect, stall, CPU-space read port, OAM write port, done pulse).
// Macro OAM_DMA_ALIGN_EN: when defined, a trigger on an odd CPU cycle inserts one
// ALIGN cycle; when undefined, align is always 0 and ALIGN is never entered.
module oam_dma_ctrl
    import nes_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
    parameter int          XFER_LEN     = XFER_LEN_DEFAULT
) (
    input logic            clk,
    input logic            reset,
    oam_dma_ctrl_if.master bus
);
`ifdef OAM_DMA_ALIGN_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif
    localparam logic [7:0] LAST = 8'(XFER_LEN - 1);

    dma_state_t  state, state_n;
    logic        parity, align, done_q, trig, last;
    logic [7:0]  page, base, index;
    logic [15:0] addr_q;

    assign trig = state == IDLE && bus.cpu_wr && bus.cpu_addr == DMA_REG_ADDR;
    assign last = index == LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            parity <= 1'b0;
            align  <= 1'b0;
            done_q <= 1'b0;
            page   <= '0;
            base   <= '0;
            index  <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_n;
            parity <= ~parity;
            done_q <= state == WRITE && last;
            if (trig) begin
                page  <= bus.cpu_data_in;
                base  <= bus.oam_base;
                index <= '0;
                align <= parity & ALIGN_EN;
            end
            if (state == READ)
                addr_q <= {page, index};
            if (state == WRITE && !last)
                index <= index + 8'd1;
        end
    end

    // mem_addr is live during READ and otherwise holds the last read address,
    // so the registered copy only needs to be updated in READ.
    always_comb begin
        state_n          = state == IDLE  ? (trig ? DUMMY : IDLE) :
                           state == DUMMY ? (align ? ALIGN : READ) :
                           state == ALIGN ? READ :
                           state == READ  ? WRITE :
                           (last ? IDLE : READ);
        bus.cpu_stall    = state != IDLE;
        bus.oam_dma      = state != IDLE;
        bus.mem_rd       = state == READ;
        bus.mem_addr     = state == READ ? {page, index} : addr_q;
        bus.oam_we       = state == WRITE;
        bus.oam_addr     = state == WRITE ? base + index : 8'h00;
        bus.oam_data_out = state == WRITE ? bus.mem_data_in : 8'h00;
        bus.done         = done_q;
    end
endmodule
